// File: rtl/jump_resolve_unit.sv
// -----------------------------------------------------------------------------
// jump_resolve_unit
//
// Purpose:
//   Sequential jump resolver that sits between decode and fetch. It accepts one
//   decoded instruction per valid/ready handshake and resolves J/JR/JAL/JALR
//   targets. It drives a registered fetch redirect and a link-register write
//   for JAL/JALR. After the redirect is taken, it holds a flush window for a
//   configurable number of cycles. It also keeps a small circular
//   return-address stack (RAS). Fetch uses the RAS top as a JR prediction.
//
// Ports:
//   clk, rst          clock and asynchronous active-high reset
//   valid_in/in_ready decode handshake; in_ready is high only while IDLE
//   opcode            instruction opcode (J=00100, JR=00101, JAL=00110,
//                     JALR=00111, any other opcode is accepted and ignored)
//   pc_plus2          address of the next sequential instruction
//   imm               sign-extended displacement
//   rs_data           source register value for JR/JALR
//   stall_in          fetch cannot take the redirect this cycle
//   redirect_valid    resolved target is presented to fetch
//   redirect_target   resolved jump target (registered)
//   flush             squash younger instructions
//   link_we           one-cycle link write, in the cycle the redirect is taken
//   link_addr         constant LINK_REG
//   link_data         pc_plus2 captured when the jump was accepted
//   ras_top           predicted return address, 0 when the stack is empty
//   ras_empty         stack holds no entries
// -----------------------------------------------------------------------------
module jump_resolve_unit #(
   parameter int WIDTH        = 16,
   parameter int OPW          = 5,
   parameter int REG_AW       = 3,
   parameter int LINK_REG     = 7,
   parameter int RAS_DEPTH    = 4,   // power of two, >= 2
   parameter int FLUSH_CYCLES = 2    // >= 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_in,
   output logic              in_ready,
   input  logic [OPW-1:0]    opcode,
   input  logic [WIDTH-1:0]  pc_plus2,
   input  logic [WIDTH-1:0]  imm,
   input  logic [WIDTH-1:0]  rs_data,
   input  logic              stall_in,
   output logic              redirect_valid,
   output logic [WIDTH-1:0]  redirect_target,
   output logic              flush,
   output logic              link_we,
   output logic [REG_AW-1:0] link_addr,
   output logic [WIDTH-1:0]  link_data,
   output logic [WIDTH-1:0]  ras_top,
   output logic              ras_empty
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RESOLVE = 2'd1;
   localparam logic [1:0] ST_FLUSH   = 2'd2;

   localparam logic [OPW-1:0] OP_J    = OPW'(4);
   localparam logic [OPW-1:0] OP_JR   = OPW'(5);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(6);
   localparam logic [OPW-1:0] OP_JALR = OPW'(7);

   localparam logic [CW-1:0] CNT_LOAD = CW'(FLUSH_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW:0]   RAS_FULL = (PW + 1)'(RAS_DEPTH);
   localparam logic [PW:0]   RAS_ONE  = (PW + 1)'(1);

   logic [1:0]       state;
   logic [CW-1:0]    flush_cnt;
   logic [WIDTH-1:0] target_q;
   logic             link_q;
   logic [WIDTH-1:0] link_data_q;

   logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
   logic [PW-1:0]    ras_ptr;   // next slot to write; top lives at ras_ptr-1
   logic [PW:0]      ras_cnt;

   logic             is_j, is_jr, is_jal, is_jalr;
   logic             is_jump, is_link, accept, taken;
   logic [WIDTH-1:0] target_next;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      is_j        = (opcode == OP_J);
      is_jr       = (opcode == OP_JR);
      is_jal      = (opcode == OP_JAL);
      is_jalr     = (opcode == OP_JALR);
      is_jump     = is_j | is_jr | is_jal | is_jalr;
      is_link     = is_jal | is_jalr;
      accept      = valid_in & in_ready;
      taken       = (state == ST_RESOLVE) & ~stall_in;
      // Register-relative forms use rs_data as base; the add wraps mod 2^WIDTH.
      target_next = ((is_jr | is_jalr) ? rs_data : pc_plus2) + imm;
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         flush_cnt   <= '0;
         target_q    <= '0;
         link_q      <= 1'b0;
         link_data_q <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && is_jump) begin
                  state       <= ST_RESOLVE;
                  target_q    <= target_next;
                  link_q      <= is_link;
                  link_data_q <= pc_plus2;
               end
            end
            ST_RESOLVE: begin
               // Target and link flag stay frozen while fetch stalls.
               if (!stall_in) begin
                  if (FLUSH_CYCLES > 1) begin
                     state     <= ST_FLUSH;
                     flush_cnt <= CNT_LOAD;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
            end
            ST_FLUSH: begin
               if (flush_cnt <= CNT_ONE) begin
                  state     <= ST_IDLE;
                  flush_cnt <= '0;
               end else begin
                  flush_cnt <= flush_cnt - CNT_ONE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Return-address stack. When the stack is full, a push overwrites the
   // oldest entry because the pointer wraps, and the count saturates.
   // NOTE: the entries are cleared by reset so that ras_top has a defined
   // value after reset. This costs a reset on every storage flop. Omit that
   // reset only where stale contents are never visible.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            ras_mem[i] <= '0;
         end
         ras_ptr <= '0;
         ras_cnt <= '0;
      end else if (accept) begin
         if (is_link) begin
            ras_mem[ras_ptr] <= pc_plus2;
            ras_ptr          <= ras_ptr + PTR_ONE;
            if (ras_cnt != RAS_FULL) begin
               ras_cnt <= ras_cnt + RAS_ONE;
            end
         end else if (is_jr && (ras_cnt != '0)) begin
            ras_ptr <= ras_ptr - PTR_ONE;
            ras_cnt <= ras_cnt - RAS_ONE;
         end
      end
   end

   assign in_ready        = (state == ST_IDLE);
   assign redirect_valid  = (state == ST_RESOLVE);
   assign redirect_target = target_q;
   assign flush           = (state != ST_IDLE);
   assign link_we         = taken & link_q;
   assign link_addr       = REG_AW'(LINK_REG);
   assign link_data       = link_data_q;
   assign ras_empty       = (ras_cnt == '0);
   assign ras_top         = ras_empty ? '0 : ras_mem[ras_ptr - PTR_ONE];

endmodule

// File: tb/tb_jump_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_jump_resolve_unit
//
// Directed self-checking bench for jump_resolve_unit with default parameters.
// The reference model is transaction-level. It tracks the phase of the
// accepted jump (resolving, or N flush cycles still owed) and keeps the RAS
// as a bounded queue. A negedge process compares every output against the
// model. Literal expectations pin the model against the hand-computed values.
// -----------------------------------------------------------------------------
module tb_jump_resolve_unit;

   localparam int FLUSH_CYCLES = 2;
   localparam int RAS_DEPTH    = 4;

   logic        clk;
   logic        rst;
   logic        valid_in;
   logic        in_ready;
   logic [4:0]  opcode;
   logic [15:0] pc_plus2;
   logic [15:0] imm;
   logic [15:0] rs_data;
   logic        stall_in;
   logic        redirect_valid;
   logic [15:0] redirect_target;
   logic        flush;
   logic        link_we;
   logic [2:0]  link_addr;
   logic [15:0] link_data;
   logic [15:0] ras_top;
   logic        ras_empty;

   int n_cmp = 0;
   int n_bad = 0;
   bit run_cmp = 0;

   jump_resolve_unit dut (
      .clk             (clk),
      .rst             (rst),
      .valid_in        (valid_in),
      .in_ready        (in_ready),
      .opcode          (opcode),
      .pc_plus2        (pc_plus2),
      .imm             (imm),
      .rs_data         (rs_data),
      .stall_in        (stall_in),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .flush           (flush),
      .link_we         (link_we),
      .link_addr       (link_addr),
      .link_data       (link_data),
      .ras_top         (ras_top),
      .ras_empty       (ras_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   bit          m_resolving;
   int          m_flush_left;
   logic [15:0] m_target;
   bit          m_link;
   logic [15:0] m_link_data;
   logic [15:0] m_ras[$];

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_resolving  = 0;
         m_flush_left = 0;
         m_target     = '0;
         m_link       = 0;
         m_link_data  = '0;
         m_ras.delete();
      end else if (m_resolving) begin
         if (!stall_in) begin
            m_resolving  = 0;
            m_flush_left = FLUSH_CYCLES - 1;
         end
      end else if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (valid_in) begin
         case (opcode)
            5'b00100, 5'b00101, 5'b00110, 5'b00111: begin
               m_resolving = 1;
               m_target    = ((opcode[0]) ? rs_data : pc_plus2) + imm;
               m_link      = opcode[1];
               m_link_data = pc_plus2;
               if (opcode[1]) begin
                  m_ras.push_back(pc_plus2);
                  if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
               end else if (opcode[0] && m_ras.size() > 0) begin
                  void'(m_ras.pop_back());
               end
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      if (run_cmp && !rst) begin
         check("in_ready", in_ready, (!m_resolving && m_flush_left == 0));
         check("redirect_valid", redirect_valid, m_resolving);
         check("redirect_target", redirect_target, m_target);
         check("flush", flush, (m_resolving || m_flush_left > 0));
         check("link_we", link_we, (m_resolving && !stall_in && m_link));
         check("link_addr", link_addr, 3'd7);
         check("link_data", link_data, m_link_data);
         check("ras_empty", ras_empty, (m_ras.size() == 0));
         check("ras_top", ras_top, (m_ras.size() == 0) ? 16'h0 : m_ras[m_ras.size() - 1]);
      end
   end

   // ---------------- stimulus helpers ----------------
   // Raise valid_in, wait (bounded) for in_ready, and return #1 after the
   // accepting edge, which is the first cycle the registered outputs show it.
   task automatic issue(input logic [4:0] op, input logic [15:0] pc,
                        input logic [15:0] im, input logic [15:0] rs);
      int n;
      valid_in = 1'b1;
      opcode   = op;
      pc_plus2 = pc;
      imm      = im;
      rs_data  = rs;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         check("accept_timeout", in_ready, 1'b1);
      end else begin
         @(posedge clk); #1;
      end
      valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) check("idle_timeout", in_ready, 1'b1);
   endtask

   initial begin
      rst = 1'b1; valid_in = 1'b0; opcode = '0; pc_plus2 = '0;
      imm = '0; rs_data = '0; stall_in = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_redirect_valid", redirect_valid, 1'b0);
      check("rst_target", redirect_target, 16'h0);
      check("rst_flush", flush, 1'b0);
      check("rst_link_we", link_we, 1'b0);
      check("rst_ras_empty", ras_empty, 1'b1);
      run_cmp = 1;
      @(posedge clk); #1;

      // J with wrap: 0x0010 + 0xFFF0 = 0x0000
      issue(5'b00100, 16'h0010, 16'hFFF0, 16'h0);
      check("j_valid", redirect_valid, 1'b1);
      check("j_target", redirect_target, 16'h0000);
      check("j_flush1", flush, 1'b1);
      check("j_ready1", in_ready, 1'b0);
      @(posedge clk); #1;
      check("j_flush2", flush, 1'b1);
      check("j_valid2", redirect_valid, 1'b0);
      @(posedge clk); #1;
      check("j_flush3", flush, 1'b0);
      check("j_ready3", in_ready, 1'b1);

      // JAL
      issue(5'b00110, 16'h0102, 16'h0020, 16'h0);
      check("jal_target", redirect_target, 16'h0122);
      check("jal_link_we", link_we, 1'b1);
      check("jal_link_addr", link_addr, 3'd7);
      check("jal_link_data", link_data, 16'h0102);
      check("jal_ras_top", ras_top, 16'h0102);
      check("jal_ras_empty", ras_empty, 1'b0);
      wait_idle();

      // JALR under a 3-cycle stall
      stall_in = 1'b1;
      issue(5'b00111, 16'h0200, 16'h0004, 16'h4000);
      for (int i = 0; i < 3; i++) begin
         check("jalr_hold_valid", redirect_valid, 1'b1);
         check("jalr_hold_target", redirect_target, 16'h4004);
         check("jalr_hold_link_we", link_we, 1'b0);
         @(posedge clk); #1;
      end
      stall_in = 1'b0;
      #1;
      check("jalr_taken_link_we", link_we, 1'b1);
      check("jalr_taken_valid", redirect_valid, 1'b1);
      @(posedge clk); #1;
      check("jalr_after_link_we", link_we, 1'b0);
      check("jalr_after_flush", flush, 1'b1);
      wait_idle();

      // RAS overflow then drain
      for (int k = 1; k <= 5; k++) begin
         issue(5'b00110, 16'(k * 16), 16'h0, 16'h0);
         wait_idle();
      end
      check("ras_top_full", ras_top, 16'h0050);
      begin
         logic [15:0] exp_top [5];
         exp_top[0] = 16'h0040; exp_top[1] = 16'h0030; exp_top[2] = 16'h0020;
         exp_top[3] = 16'h0000; exp_top[4] = 16'h0000;
         for (int k = 0; k < 5; k++) begin
            issue(5'b00101, 16'h0, 16'h0002, 16'hFFFF);
            check("jr_target_wrap", redirect_target, 16'h0001);
            check("jr_ras_top", ras_top, exp_top[k]);
            wait_idle();
         end
      end
      check("jr_ras_empty", ras_empty, 1'b1);

      // Reset in the FLUSH cycle after a JAL
      issue(5'b00110, 16'h0300, 16'h0010, 16'h0);
      @(posedge clk); #1;
      check("pre_rst_flush", flush, 1'b1);
      rst = 1'b1;
      #1;
      check("mid_rst_flush", flush, 1'b0);
      check("mid_rst_valid", redirect_valid, 1'b0);
      check("mid_rst_link_we", link_we, 1'b0);
      check("mid_rst_ras_empty", ras_empty, 1'b1);
      check("mid_rst_link_data", link_data, 16'h0);
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      check("post_rst_ready", in_ready, 1'b1);
      @(posedge clk); #1;

      // Non-jump opcode leaves everything alone
      issue(5'b00110, 16'h0ABC, 16'h0002, 16'h0);
      wait_idle();
      issue(5'b01000, 16'h1234, 16'h0100, 16'h5555);
      check("nj_ready", in_ready, 1'b1);
      check("nj_valid", redirect_valid, 1'b0);
      check("nj_flush", flush, 1'b0);
      check("nj_target_hold", redirect_target, 16'h0ABE);
      check("nj_ras_top", ras_top, 16'h0ABC);
      @(posedge clk); #1;

      run_cmp = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/jump_resolve_unit.md
Name: jump_resolve_unit

Overview:
- Parametrised, sequential successor to the combinational jump decode. Accepts one decoded instruction per handshake and resolves J/JR/JAL/JALR targets.
- Drives a registered fetch redirect, and a link-register write for JAL/JALR.
- Holds a flush window for a configurable number of cycles.
- Keeps a small return-address stack (RAS) that fetch uses for early JR prediction.
- Sits between decode and fetch/register-file write port.

Parameters:
- WIDTH, 16, PC/data width in bits.
- OPW, 5, opcode width.
- REG_AW, 3, register address width.
- LINK_REG, 7, register index written on JAL/JALR.
- RAS_DEPTH, 4, return-address stack entries; must be a power of two, >=2.
- FLUSH_CYCLES, 2, cycles flush stays high after redirect fires; must be >=1.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- valid_in  in  1  decode presents an instruction
- in_ready  out  1  unit can accept; combinational: state==IDLE
- opcode  in  OPW  instruction opcode
- pc_plus2  in  WIDTH  address of the next sequential instruction
- imm  in  WIDTH  sign-extended displacement
- rs_data  in  WIDTH  source register value (used by JR/JALR)
- stall_in  in  1  fetch cannot take a redirect this cycle
- redirect_valid  out  1  redirect target is valid
- redirect_target  out  WIDTH  resolved jump target
- flush  out  1  squash younger instructions
- link_we  out  1  link register write enable
- link_addr  out  REG_AW  always LINK_REG
- link_data  out  WIDTH  pc_plus2 captured at acceptance
- ras_top  out  WIDTH  current RAS top (predicted JR target); 0 when empty
- ras_empty  out  1  RAS holds no entries

Behaviour:
- Opcodes:
  - J = 00100: target = pc_plus2 + imm.
  - JR = 00101: target = rs_data + imm.
  - JAL = 00110: as J, plus link.
  - JALR = 00111: as JR, plus link.
  - Any other opcode: accepted, ignored, no state change.
- Arithmetic is modulo 2^WIDTH; overflow wraps silently.
- Handshake: accept when valid_in && in_ready. A jump opcode latches the target, link flag and pc_plus2, and moves IDLE->RESOLVE.
- FSM states: IDLE, RESOLVE, FLUSH.
- RESOLVE:
  - redirect_valid=1 and flush=1, held while stall_in=1; the target stays stable.
  - On the first cycle with stall_in=0, the redirect is taken.
  - link_we pulses in that cycle only, and only for JAL/JALR.
  - Next state: FLUSH if FLUSH_CYCLES>1, else IDLE.
- FLUSH:
  - flush=1, redirect_valid=0.
  - Down-counter loaded with FLUSH_CYCLES-1 on the taken cycle; decrements each cycle; exits to IDLE when it reaches 1.
  - Total flush-high cycles after the taken cycle = FLUSH_CYCLES-1, plus the taken cycle itself.
- Latency: acceptance in cycle N -> redirect_valid in cycle N+1 (registered). Earliest next acceptance: cycle N+1+FLUSH_CYCLES.
- RAS push/pop happens at acceptance:
  - JAL/JALR push pc_plus2.
  - JR pops.
  - J has no RAS effect.
- RAS full: push overwrites the oldest entry (circular pointer wraps mod RAS_DEPTH); count saturates at RAS_DEPTH.
- RAS empty: a JR pop is a no-op; ras_empty stays 1, ras_top=0.
- Prediction only: ras_top never alters redirect_target.
- Reset, asynchronous and valid at any point including mid-RESOLVE/FLUSH:
  - State=IDLE, counter=0, RAS count/pointer=0, entries=0.
  - redirect_valid=0, redirect_target=0, flush=0, link_we=0, link_data=0, ras_top=0, ras_empty=1.
  - in_ready=1 once reset deasserts.
- valid_in while not in_ready is ignored; decode must hold it.

Test Plan:
- Reset, then J at pc_plus2=0x0010, imm=0xFFF0 -> one cycle later redirect_target=0x0000, redirect_valid=1. flush high 2 cycles, link_we never asserts, in_ready returns on cycle 3.
- JAL at pc_plus2=0x0102, imm=0x0020 -> target 0x0122; link_we=1 with link_addr=7, link_data=0x0102 in the taken cycle; ras_top=0x0102, ras_empty=0.
- JALR with rs_data=0x4000, imm=0x0004, stall_in high 3 cycles -> redirect_valid and target 0x4004 held 3 cycles; link_we fires once, on the cycle stall_in drops.
- 5 JALs with pc_plus2=0x10,0x20,0x30,0x40,0x50, then 5 JRs (RAS_DEPTH=4) -> ras_top before the JRs is 0x50; it pops to 0x40, 0x30, 0x20, then empty. The 5th JR leaves ras_empty=1 with no error.
- Assert rst in the FLUSH cycle after a JAL -> flush, redirect_valid and link_we are 0 immediately; ras_empty=1; in_ready=1 after release.
- Non-jump opcode 01000 with valid_in -> accepted, no redirect/flush/link; RAS unchanged; in_ready stays 1.
